// File: rtl/gpx2_rx_pkg.sv
// gpx2_rx_pkg: shared constants and state encodings for the GPX2 LVDS receiver.
// Optional build macro used by the receiver files: GPX2_FRAME_CHECK_EN.
package gpx2_rx_pkg;

  localparam int NUM_CH_DEF  = 8;
  localparam int WIN_CYC_DEF = 2000;
  localparam int WORD_W      = 24;
  localparam int ECHO_N      = 3;
  localparam int REC_W       = ECHO_N * WORD_W;
  localparam int CNT_W       = 2;
  localparam int BIT_CNT_W   = 5;

  localparam logic [WORD_W-1:0]    FRAME_PAT = 24'hFF0000;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 5'd23;

  typedef enum logic [1:0] {
    WIN_IDLE    = 2'd0,
    WIN_COLLECT = 2'd1,
    WIN_DONE    = 2'd2
  } win_state_t;

  typedef enum logic {
    DES_IDLE  = 1'b0,
    DES_SHIFT = 1'b1
  } deser_state_t;

  // Expected FRAME level for a given bit index of a word (bit 0 = MSB slot).
  function automatic logic frame_expected(input logic [BIT_CNT_W-1:0] bit_idx);
    logic [WORD_W-1:0] pat;
    pat = FRAME_PAT;
    return pat[5'd23 - bit_idx];
  endfunction

endpackage

// File: rtl/gpx2_lvds_deser.sv
// gpx2_lvds_deser: single-channel GPX2 FRAME/SDO deserializer.
// A FRAME rising edge starts a 24-bit MSB-first word; the word and a one-cycle
// valid pulse are registered after the 24th bit.
// With GPX2_FRAME_CHECK_EN defined, FRAME is checked against the 0xFF0000
// pattern during the word and any mismatch aborts it with a frm_err pulse.
module gpx2_lvds_deser
  import gpx2_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame,
  input  logic              sdo,
  output logic [WORD_W-1:0] word,
  output logic              word_vld
`ifdef GPX2_FRAME_CHECK_EN
  ,
  output logic              frm_err
`endif
);

  deser_state_t           state_r;
  logic                   frame_d_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic [WORD_W-2:0]      shreg_r;
  logic [WORD_W-1:0]      word_r;
  logic                   vld_r;
  logic                   frame_rise_s;
  logic                   frame_bad_s;
`ifdef GPX2_FRAME_CHECK_EN
  logic                   frm_err_r;
`endif

  assign frame_rise_s = frame & ~frame_d_r;

`ifdef GPX2_FRAME_CHECK_EN
  assign frame_bad_s = (frame != frame_expected(bit_cnt_r));
  assign frm_err     = frm_err_r;
`else
  assign frame_bad_s = 1'b0;
`endif

  assign word     = word_r;
  assign word_vld = vld_r;

  // Word framing FSM: start on FRAME edge, shift 24 bits, register word + pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= DES_IDLE;
      frame_d_r <= 1'b0;
      bit_cnt_r <= {BIT_CNT_W{1'b0}};
      shreg_r   <= {(WORD_W-1){1'b0}};
      word_r    <= {WORD_W{1'b0}};
      vld_r     <= 1'b0;
`ifdef GPX2_FRAME_CHECK_EN
      frm_err_r <= 1'b0;
`endif
    end else begin
      frame_d_r <= frame;
      vld_r     <= 1'b0;
`ifdef GPX2_FRAME_CHECK_EN
      frm_err_r <= 1'b0;
`endif
      case (state_r)
        DES_IDLE: begin
          if (frame_rise_s) begin
            // The edge cycle carries the MSB.
            state_r   <= DES_SHIFT;
            shreg_r   <= {{(WORD_W-2){1'b0}}, sdo};
            bit_cnt_r <= 5'd1;
          end else begin
            state_r <= DES_IDLE;
          end
        end
        DES_SHIFT: begin
          if (frame_bad_s) begin
            state_r   <= DES_IDLE;
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
`ifdef GPX2_FRAME_CHECK_EN
            frm_err_r <= 1'b1;
`endif
          end else if (bit_cnt_r == LAST_BIT) begin
            word_r    <= {shreg_r, sdo};
            vld_r     <= 1'b1;
            state_r   <= DES_IDLE;
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
          end else begin
            shreg_r   <= {shreg_r[WORD_W-3:0], sdo};
            bit_cnt_r <= bit_cnt_r + 5'd1;
          end
        end
        default: begin
          state_r   <= DES_IDLE;
          bit_cnt_r <= {BIT_CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/gpx2_lvds_rx.sv
// gpx2_lvds_rx: GPX2 TDC serial result receiver, NUM_CH channels.
// Registers FRAME/SDO/trigger once, deserializes each channel, collects up to
// ECHO_N words per channel inside a WIN_CYC-cycle window opened by the trigger
// rising edge and publishes 72-bit shot records with a one-cycle enable.
// Build macro GPX2_FRAME_CHECK_EN adds FRAME pattern checking and CpSv_FrmErr_o.
module gpx2_lvds_rx
  import gpx2_rx_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int WIN_CYC = WIN_CYC_DEF
)
(
  input  logic                    CpSl_Clk200M_i,
  input  logic                    CpSl_Rst_iN,
  input  logic                    CpSl_LadarTrig_i,
  input  logic [NUM_CH-1:0]       CpSv_Frame_i,
  input  logic [NUM_CH-1:0]       CpSv_Sdo_i,
  output logic [NUM_CH*REC_W-1:0] CpSv_FrameData_o,
  output logic                    CpSl_FrameDataEn_o,
  output logic [NUM_CH*CNT_W-1:0] CpSv_EchoCnt_o,
  output logic                    CpSl_Ovf_o
`ifdef GPX2_FRAME_CHECK_EN
  ,
  output logic [NUM_CH-1:0]       CpSv_FrmErr_o
`endif
);

  localparam int TMR_W = $clog2(WIN_CYC);

  logic [NUM_CH-1:0] frame_r;
  logic [NUM_CH-1:0] sdo_r;
  logic              trig_r;
  logic              trig_d_r;
  logic              trig_edge_s;

  logic [WORD_W-1:0] word_s [NUM_CH];
  logic [NUM_CH-1:0] vld_s;

  win_state_t        win_state_r;
  logic [TMR_W-1:0]  timer_r;
  logic [WORD_W-1:0] slot_r [NUM_CH][ECHO_N];
  logic [CNT_W-1:0]  cnt_r  [NUM_CH];

  assign trig_edge_s = trig_r & ~trig_d_r;

  // Single input register stage for all serial lines and the trigger.
  always_ff @(posedge CpSl_Clk200M_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      frame_r  <= {NUM_CH{1'b0}};
      sdo_r    <= {NUM_CH{1'b0}};
      trig_r   <= 1'b0;
      trig_d_r <= 1'b0;
    end else begin
      frame_r  <= CpSv_Frame_i;
      sdo_r    <= CpSv_Sdo_i;
      trig_r   <= CpSl_LadarTrig_i;
      trig_d_r <= trig_r;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gpx2_lvds_deser u_deser (
      .clk      (CpSl_Clk200M_i),
      .rst_n    (CpSl_Rst_iN),
      .frame    (frame_r[g]),
      .sdo      (sdo_r[g]),
      .word     (word_s[g]),
      .word_vld (vld_s[g])
`ifdef GPX2_FRAME_CHECK_EN
      ,
      .frm_err  (CpSv_FrmErr_o[g])
`endif
    );
  end

  // Window FSM: open on trigger edge, collect echoes, publish records on DONE.
  always_ff @(posedge CpSl_Clk200M_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      win_state_r        <= WIN_IDLE;
      timer_r            <= {TMR_W{1'b0}};
      CpSv_FrameData_o   <= {(NUM_CH*REC_W){1'b0}};
      CpSl_FrameDataEn_o <= 1'b0;
      CpSv_EchoCnt_o     <= {(NUM_CH*CNT_W){1'b0}};
      CpSl_Ovf_o         <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_r[c] <= {CNT_W{1'b0}};
        for (int e = 0; e < ECHO_N; e++) begin
          slot_r[c][e] <= {WORD_W{1'b0}};
        end
      end
    end else begin
      CpSl_FrameDataEn_o <= 1'b0;
      case (win_state_r)
        WIN_IDLE: begin
          if (trig_edge_s) begin
            win_state_r <= WIN_COLLECT;
            timer_r     <= {TMR_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
              cnt_r[c] <= {CNT_W{1'b0}};
              for (int e = 0; e < ECHO_N; e++) begin
                slot_r[c][e] <= {WORD_W{1'b0}};
              end
            end
          end else begin
            win_state_r <= WIN_IDLE;
          end
        end
        WIN_COLLECT: begin
          timer_r <= timer_r + TMR_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (vld_s[c]) begin
              if (cnt_r[c] == CNT_W'(ECHO_N)) begin
                // Slots full: drop the word and flag overflow until reset.
                CpSl_Ovf_o <= 1'b1;
              end else begin
                for (int e = 0; e < ECHO_N; e++) begin
                  if (cnt_r[c] == CNT_W'(e)) begin
                    slot_r[c][e] <= word_s[c];
                  end
                end
                cnt_r[c] <= cnt_r[c] + CNT_W'(1);
              end
            end
          end
          if (timer_r == TMR_W'(WIN_CYC - 1)) begin
            win_state_r <= WIN_DONE;
          end else begin
            win_state_r <= WIN_COLLECT;
          end
        end
        WIN_DONE: begin
          for (int c = 0; c < NUM_CH; c++) begin
            for (int e = 0; e < ECHO_N; e++) begin
              // echo1 occupies the most significant field of the record.
              CpSv_FrameData_o[c*REC_W + (ECHO_N-1-e)*WORD_W +: WORD_W] <= slot_r[c][e];
            end
            CpSv_EchoCnt_o[c*CNT_W +: CNT_W] <= cnt_r[c];
          end
          CpSl_FrameDataEn_o <= 1'b1;
          win_state_r        <= WIN_IDLE;
        end
        default: begin
          win_state_r <= WIN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpx2_lvds_rx.sv
// tb_gpx2_lvds_rx: randomized self-checking bench for gpx2_lvds_rx.
// Words are scheduled per shot as (channel, start offset, value, frame drop
// bit); a shot-level model decides which words land in which echo slot.
// Honours GPX2_FRAME_CHECK_EN for the optional error port.
module tb_gpx2_lvds_rx;

  localparam int NCH = 8;
  localparam int WIN = 2000;
`ifdef GPX2_FRAME_CHECK_EN
  localparam bit FRAME_CHK = 1'b1;
`else
  localparam bit FRAME_CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             trig = 1'b0;
  logic [NCH-1:0]   frame_pins = 8'h00;
  logic [NCH-1:0]   sdo_pins = 8'h00;
  logic [NCH*72-1:0] fdata;
  logic             fen;
  logic [NCH*2-1:0] ecnt;
  logic             ovf;
`ifdef GPX2_FRAME_CHECK_EN
  logic [NCH-1:0]   frmerr;
`endif

  gpx2_lvds_rx dut (
    .CpSl_Clk200M_i     (clk),
    .CpSl_Rst_iN        (rst_n),
    .CpSl_LadarTrig_i   (trig),
    .CpSv_Frame_i       (frame_pins),
    .CpSv_Sdo_i         (sdo_pins),
    .CpSv_FrameData_o   (fdata),
    .CpSl_FrameDataEn_o (fen),
    .CpSv_EchoCnt_o     (ecnt),
    .CpSl_Ovf_o         (ovf)
`ifdef GPX2_FRAME_CHECK_EN
    ,
    .CpSv_FrmErr_o      (frmerr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    int          start;
    logic [23:0] w;
    int          drop;
  } wtx_t;

  wtx_t        sched[$];
  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_rec [NCH];
  int          exp_cnt [NCH];
  bit          ovf_model = 1'b0;
  int          en_cnt;
  int          en_edge;
  int          p_edge;
  int          ferr_cnt [NCH];

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Pin levels for the edge at offset 'off' from the trigger-sampling edge.
  task automatic drive_pins(input int off);
    logic [NCH-1:0] f;
    logic [NCH-1:0] s;
    int idx;
    f = 8'h00;
    s = 8'h00;
    foreach (sched[i]) begin
      idx = off - sched[i].start;
      if (idx >= 0 && idx < 24) begin
        s[sched[i].ch] = sched[i].w[23-idx];
        if (sched[i].drop >= 0 && idx >= sched[i].drop) f[sched[i].ch] = 1'b0;
        else f[sched[i].ch] = (idx < 8);
      end
    end
    frame_pins = f;
    sdo_pins   = s;
  endtask

  task automatic run_shot(input int rst_off);
    en_cnt  = 0;
    en_edge = -1;
    for (int c = 0; c < NCH; c++) ferr_cnt[c] = 0;
    @(negedge clk);
    trig   = 1'b1;
    p_edge = cyc + 1;
    drive_pins(0);
    for (int k = 1; k <= WIN + 40; k++) begin
      @(negedge clk);
      if (fen) begin
        en_cnt++;
        en_edge = cyc;
      end
`ifdef GPX2_FRAME_CHECK_EN
      for (int c = 0; c < NCH; c++) if (frmerr[c]) ferr_cnt[c]++;
`endif
      trig  = (k < 4);
      rst_n = !(rst_off >= 0 && k >= rst_off && k < rst_off + 3);
      drive_pins(k);
    end
    frame_pins = 8'h00;
    sdo_pins   = 8'h00;
  endtask

  // Shot model: a word is usable 25 edges after its MSB is sampled; it counts
  // if that lands while the window (timer 0..WIN-1) is open.
  task automatic model_shot();
    int n;
    int done_off;
    for (int c = 0; c < NCH; c++) begin
      n = 0;
      exp_rec[c] = 72'h0;
      foreach (sched[i]) begin
        if (sched[i].ch == c && !(FRAME_CHK && sched[i].drop >= 1 && sched[i].drop < 8)) begin
          done_off = sched[i].start + 25;
          if (done_off >= 2 && done_off <= WIN + 1) begin
            if (n < 3) exp_rec[c][71 - 24*n -: 24] = sched[i].w;
            else ovf_model = 1'b1;
            n++;
          end
        end
      end
      exp_cnt[c] = (n > 3) ? 3 : n;
    end
  endtask

  task automatic check_shot(input string tag);
    model_shot();
    check_eq({tag, "_en_cnt"}, 72'(en_cnt), 72'd1);
    check_eq({tag, "_en_edge"}, 72'(en_edge), 72'(p_edge + WIN + 2));
    for (int c = 0; c < NCH; c++) begin
      check_eq($sformatf("%s_rec%0d", tag, c), fdata[c*72 +: 72], exp_rec[c]);
      check_eq($sformatf("%s_cnt%0d", tag, c), 72'(ecnt[c*2 +: 2]), 72'(exp_cnt[c]));
    end
    check_eq({tag, "_ovf"}, 72'(ovf), 72'(ovf_model));
  endtask

  task automatic push_word(input int ch, input int start, input logic [23:0] w, input int drop);
    wtx_t t;
    t.ch = ch; t.start = start; t.w = w; t.drop = drop;
    sched.push_back(t);
  endtask

  initial begin
    int t;
    int n;
    int rch;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++) check_eq($sformatf("rst_rec%0d", c), fdata[c*72 +: 72], 72'h0);
    check_eq("rst_en", 72'(fen), 72'h0);
    check_eq("rst_cnt", 72'(ecnt), 72'h0);
    check_eq("rst_ovf", 72'(ovf), 72'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word on channel 1.
    sched.delete();
    push_word(0, 10, 24'hABCDEF, -1);
    run_shot(-1);
    check_shot("one");
    check_eq("one_rec_direct", fdata[71:0], 72'hABCDEF000000000000);

    // Three words on every channel, 50 idle cycles apart.
    sched.delete();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 3; i++) push_word(c, 10 + i*74, 24'(24'h111111 * (i + 1)), -1);
    run_shot(-1);
    check_shot("full");
    for (int c = 0; c < NCH; c++) check_eq($sformatf("full_direct%0d", c), fdata[c*72 +: 72], 72'h111111222222333333);

    // Four words on channel 5 -> overflow.
    sched.delete();
    for (int i = 0; i < 4; i++) push_word(4, 20 + i*60, 24'($urandom), -1);
    run_shot(-1);
    check_shot("ovf");
    check_eq("ovf_direct", 72'(ovf), 72'h1);

    // Window boundary: last capturable start and one cycle later.
    sched.delete();
    push_word(1, WIN - 24, 24'($urandom), -1);
    push_word(5, WIN - 23, 24'($urandom), -1);
    run_shot(-1);
    check_shot("edge");
    check_eq("edge_in_cnt", 72'(ecnt[3:2]), 72'd1);
    check_eq("edge_out_cnt", 72'(ecnt[11:10]), 72'd0);
    check_eq("edge_ovf_sticky", 72'(ovf), 72'h1);

    // Randomized shots.
    for (int s = 0; s < 3; s++) begin
      sched.delete();
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, 4);
        t = $urandom_range(3, 300);
        for (int i = 0; i < n; i++) begin
          if (t <= WIN - 10)
            push_word(c, t, 24'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 23)) : -1);
          t += $urandom_range(26, 600);
        end
      end
      run_shot(-1);
      check_shot($sformatf("rnd%0d", s));
    end

    // Reset during bit 12 of a word inside the window.
    rch = $urandom_range(0, NCH - 1);
    sched.delete();
    push_word(rch, 100, 24'($urandom), -1);
    run_shot(112);
    ovf_model = 1'b0;
    check_eq("rst_mid_en", 72'(en_cnt), 72'd0);
    check_eq("rst_mid_ovf", 72'(ovf), 72'h0);
    check_eq("rst_mid_rec", fdata[rch*72 +: 72], 72'h0);
    sched.delete();
    push_word(rch, 30, 24'h000001, -1);
    run_shot(-1);
    check_shot("post_rst");
    check_eq("post_rst_direct", fdata[rch*72 +: 72], 72'h000001000000000000);

    // FRAME drops at bit 4 of a word on channel 3.
    sched.delete();
    push_word(2, 40, 24'h5A5A5A, 4);
    run_shot(-1);
    check_shot("fdrop");
`ifdef GPX2_FRAME_CHECK_EN
    check_eq("fdrop_err", 72'(ferr_cnt[2]), 72'd1);
    check_eq("fdrop_cnt", 72'(ecnt[5:4]), 72'd0);
`else
    check_eq("fdrop_rec", fdata[2*72 +: 72], 72'h5A5A5A000000000000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpx2_lvds_rx.md
Name: gpx2_lvds_rx

Overview:
- FPGA-side receiver for the GPX2 TDC serial result interface: 8 channels, each with one FRAME line and one SDO line.
- Each channel deserializes 24-bit MSB-first stop words framed by the 0xFF0000 frame pattern.
- Up to 3 echoes per channel are collected inside a measurement window opened by the ladar start trigger.
- At window end, all channels are presented as 72-bit shot records with a one-cycle enable. The record format is the one the TDC stimulus model consumes.

Parameters:
- NUM_CH, 8, number of TDC serial channels.
- WORD_W, 24, bits per stop word.
- ECHO_N, 3, echo slots per channel per shot.
- WIN_CYC, 2000, measurement window length in clock cycles after the trigger.

Ports:
- CpSl_Clk200M_i  in  1  200 MHz clock; also the GPX2 serial bit clock.
- CpSl_Rst_iN  in  1  reset, asynchronous, active-low.
- CpSl_LadarTrig_i  in  1  ladar start trigger, level input; its rising edge opens a window.
- CpSv_Frame_i  in  NUM_CH  FRAME lines; bit n = channel n+1.
- CpSv_Sdo_i  in  NUM_CH  SDO lines; bit n = channel n+1.
- CpSv_FrameData_o  out  NUM_CH*72  channel n at [72n+71:72n]; echo1 [71:48], echo2 [47:24], echo3 [23:0].
- CpSl_FrameDataEn_o  out  1  one-cycle pulse; CpSv_FrameData_o is valid in that cycle and held until the next pulse.
- CpSv_EchoCnt_o  out  NUM_CH*2  words captured per channel in the last shot (0..3).
- CpSl_Ovf_o  out  1  sticky; set when any channel gets a 4th or later word in one window; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; deserializers idle; window FSM in IDLE.
- Input stage: FRAME, SDO and the trigger are registered once (stage R) on the rising edge. Trigger edge detect = R & ~R_d.
- Deserializer, per channel, states IDLE / SHIFT:
  - IDLE -> SHIFT on a FRAME rising edge (R & ~R_d); that cycle's SDO is the MSB.
  - SHIFT: shift one SDO bit per cycle; a 5-bit bit counter counts 0..23.
  - After the 24th bit, the word and a valid pulse are registered and the FSM returns to IDLE.
  - Latency: if the MSB is at the pin on edge T, the word is valid at edge T+25 (pulse width 1).
  - A FRAME rising edge while in SHIFT is ignored.
- Window FSM, states IDLE / COLLECT / DONE:
  - IDLE -> COLLECT on a trigger edge. Clear all echo slots to 0 and echo counters to 0; load the window timer with 0.
  - COLLECT: the timer increments each cycle. A valid word on channel n goes to slot echo_cnt[n] (0 -> echo1 field), then echo_cnt[n] increments.
  - COLLECT: when echo_cnt[n] == ECHO_N, the word is dropped and CpSl_Ovf_o is set.
  - COLLECT -> DONE when timer == WIN_CYC-1. A word valid on that same cycle is still captured.
  - DONE (1 cycle): copy slots to CpSv_FrameData_o and counts to CpSv_EchoCnt_o; pulse CpSl_FrameDataEn_o; go to IDLE.
- Words completing in IDLE or DONE are discarded.
- Trigger edges during COLLECT or DONE are ignored and do not restart the window.
- Unused echo slots read 0.
- Reset asserted mid-word or mid-window: immediate return to the reset state. No pulse is emitted and partial data is lost.

Optional Feature:
- Macro GPX2_FRAME_CHECK_EN.
- Defined:
  - In SHIFT, FRAME must be 1 for bits 0..7 and 0 for bits 8..23. Any mismatch aborts the word: deserializer returns to IDLE with no valid pulse.
  - Adds output CpSv_FrmErr_o (NUM_CH bits). Bit n pulses 1 cycle at the mismatch and is reset to 0.
- Undefined: FRAME is used only for start detection; no error port exists.

Decomposition:
- Shared package gpx2_rx_pkg holds:
  - constants: frame pattern 24'hFF0000, WORD_W, ECHO_N, record width 72;
  - window FSM state encoding;
  - deserializer state encoding.
- One sub-module, gpx2_lvds_deser: single-channel FRAME/SDO deserializer, including the frame check. Instantiated NUM_CH times via generate.
- Top level contains the input registers, window FSM, slot storage and output registers.

Test Plan:
- Trigger, then channel1 sends one word 0xABCDEF with the correct frame -> at the DONE pulse, ch1 record = 72'hABCDEF_000000_000000, EchoCnt[ch1] = 1, other channels all zero.
- Trigger, then channels 1..8 each send 3 words 0x111111 / 0x222222 / 0x333333 spaced 50 idle cycles -> every record = 72'h111111_222222_333333, every count = 3, Ovf = 0.
- Trigger, then channel5 sends 4 words -> first three stored, Ovf = 1 and stays 1 through the next shot; count = 3.
- Word whose MSB reaches the pin at timer = WIN_CYC-26 -> captured. The same word started 1 cycle later -> dropped, count = 0.
- Reset pulsed at bit 12 of a word during COLLECT -> no FrameDataEn. Next trigger plus a word 0x000001 -> record echo1 = 0x000001.
- With GPX2_FRAME_CHECK_EN: FRAME drops at bit 4 -> FrmErr[n] pulses, no word stored, count = 0. Without the macro: same stimulus stores the SDO bits as a word.
